dcache_ctrl: RTL and testbench

- Direct-mapped, write-through, no-write-allocate data-cache controller in the memory stage.
- Sits between the pipeline's memory-stage load/store signals and a slower backing data memory that uses a req/ack handshake.
- Sequences refills and write-throughs, and raises one stall that freezes the fetch, decode, execute and memory pipeline registers while a backing access is outstanding.

---
 rtl/dcache_pkg.sv | 30 +++
 rtl/dcache_array.sv | 46 ++++
 rtl/dcache_ctrl.sv | 168 ++++++++++++++++
 tb/tb_dcache_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and helpers for the direct-mapped write-through data cache.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE
    } state_t;

    function automatic int idx_width(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_width(input int addr_w, input int sets);
        return addr_w - $clog2(sets) - 2;
    endfunction

    // Byte-lane merge used when a store hits a resident line.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] result;
        result = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) result[8*i +: 8] = new_word[8*i +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage for one-word lines: asynchronous read, synchronous write.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int IDX_W      = 4,
    parameter int TAG_W      = 26
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IDX_W-1:0]      idx,
    input  logic                  wr_en,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  line_valid,
    output logic [TAG_W-1:0]      line_tag,
    output logic [DATA_WIDTH-1:0] line_data
);

    localparam int SETS = 1 << IDX_W;

    logic [SETS-1:0]       valid;
    logic [TAG_W-1:0]      tag_mem  [SETS];
    logic [DATA_WIDTH-1:0] data_mem [SETS];

    assign line_valid = valid[idx];
    assign line_tag   = tag_mem[idx];
    assign line_data  = data_mem[idx];

    // Only the valid bits need clearing; stale tags and data are masked by them.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[idx]  <= wr_tag;
            data_mem[idx] <= wr_data;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through, no-write-allocate data-cache controller.
// Define DCACHE_PERF_CNT_EN to add the hit_cnt/miss_cnt load counters.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int SETS          = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cpu_re,
    input  logic                     cpu_we,
    input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
    input  logic [3:0]               cpu_be,
    input  logic [DATA_WIDTH-1:0]    cpu_wdata,
    output logic [DATA_WIDTH-1:0]    cpu_rdata,
    output logic                     stall,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [3:0]               mem_be,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    input  logic                     mem_ack
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0]              hit_cnt,
    output logic [31:0]              miss_cnt
`endif
);

    localparam int IDX_W = idx_width(SETS);
    localparam int TAG_W = tag_width(ADDRESS_WIDTH, SETS);

    state_t                   state;
    logic [ADDRESS_WIDTH-1:0] lookup_addr;
    logic [IDX_W-1:0]         lookup_idx;
    logic [TAG_W-1:0]         lookup_tag;
    logic [1:0]               unused_addr_bits;
    logic                     line_valid;
    logic [TAG_W-1:0]         line_tag;
    logic [DATA_WIDTH-1:0]    line_data;
    logic                     hit;
    logic                     load_req;
    logic                     load_hit;
    logic                     wr_en;
    logic [DATA_WIDTH-1:0]    wr_data;
    logic [DATA_WIDTH-1:0]    rdata_q;

    // Outside IDLE the latched request address drives the lookup, so the
    // store-hit decision at the ack edge refers to the store's own line.
    assign lookup_addr      = (state == IDLE) ? cpu_addr : mem_addr;
    assign lookup_idx       = lookup_addr[IDX_W+1:2];
    assign lookup_tag       = lookup_addr[ADDRESS_WIDTH-1:IDX_W+2];
    assign unused_addr_bits = lookup_addr[1:0];

    assign hit      = line_valid && (line_tag == lookup_tag);
    assign load_req = cpu_re && !cpu_we;
    assign load_hit = (state == IDLE) && load_req && hit;

    dcache_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W),
        .TAG_W      (TAG_W)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .idx        (lookup_idx),
        .wr_en      (wr_en),
        .wr_tag     (lookup_tag),
        .wr_data    (wr_data),
        .line_valid (line_valid),
        .line_tag   (line_tag),
        .line_data  (line_data)
    );

    always_comb begin
        wr_en   = 1'b0;
        wr_data = mem_rdata;
        if (!rst && mem_ack) begin
            case (state)
                FILL:  wr_en = 1'b1;
                WRITE: begin
                    wr_en   = hit;
                    wr_data = merge_bytes(line_data, mem_wdata, mem_be);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        stall     = 1'b0;
        cpu_rdata = rdata_q;
        if (rst) begin
            cpu_rdata = '0;
        end else begin
            case (state)
                IDLE: begin
                    stall = cpu_we || (cpu_re && !hit);
                    if (load_hit) cpu_rdata = line_data;
                end
                FILL: begin
                    stall = !mem_ack;
                    if (mem_ack) cpu_rdata = mem_rdata;
                end
                WRITE:   stall = !mem_ack;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            rdata_q   <= '0;
        end else begin
            rdata_q <= cpu_rdata;
            case (state)
                IDLE: begin
                    if (cpu_we) begin
                        state     <= WRITE;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {cpu_addr[ADDRESS_WIDTH-1:2], 2'b00};
                        mem_be    <= cpu_be;
                        mem_wdata <= cpu_wdata;
                    end else if (cpu_re && !hit) begin
                        state    <= FILL;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= {cpu_addr[ADDRESS_WIDTH-1:2], 2'b00};
                        mem_be   <= '0;
                    end
                end
                FILL, WRITE: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        mem_be  <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (load_hit) hit_cnt <= hit_cnt + 32'd1;
            if ((state == IDLE) && load_req && !hit) miss_cnt <= miss_cnt + 32'd1;
        end
    end
`else
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl with a latency-programmable backing memory.
module tb_dcache_ctrl;

    logic        clk;
    logic        rst;
    logic        cpu_re;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [3:0]  cpu_be;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int ack_delay = 1;
    int req_cycles = 0;
    int exp_hits = 0;
    int exp_misses = 0;
    logic [31:0] last_load = 32'h0;
    logic [31:0] sb_q [$];
    logic [31:0] back_mem [logic [31:0]];
    logic [31:0] exp_mem  [logic [31:0]];

    dcache_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_re    (cpu_re),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_be    (cpu_be),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
`ifdef DCACHE_PERF_CNT_EN
        ,
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] default_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [31:0] tb_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] back_read(input logic [31:0] a);
        if (back_mem.exists(a)) return back_mem[a];
        return default_word(a);
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        if (exp_mem.exists(a)) return exp_mem[a];
        return default_word(a);
    endfunction

    // Backing memory: acks in the ack_delay-th request cycle and applies writes.
    always @(posedge clk) begin
        #1;
        if (rst || !mem_req) begin
            req_cycles = 0;
            mem_ack    = 1'b0;
        end else begin
            req_cycles++;
            if (req_cycles >= ack_delay) begin
                mem_ack = 1'b1;
                if (mem_we) back_mem[mem_addr] = tb_merge(back_read(mem_addr), mem_wdata, mem_be);
                else        mem_rdata = back_read(mem_addr);
                req_cycles = 0;
            end else begin
                mem_ack = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Drives one load or store and follows it to completion; exp_access says
    // whether a backing-memory transaction must occur.
    task automatic applyStimulus(input bit is_store, input bit both_flags, input logic [31:0] addr,
                                 input logic [3:0] be, input logic [31:0] wdata,
                                 input bit exp_access, input string name);
        logic [31:0] aligned;
        logic [31:0] req_addr;
        logic [31:0] exp_data;
        logic        req_we;
        logic [3:0]  req_be;
        int          stall_cycles;
        bit          saw_req;
        aligned   = {addr[31:2], 2'b00};
        cpu_re    = !is_store || both_flags;
        cpu_we    = is_store;
        cpu_addr  = addr;
        cpu_be    = be;
        cpu_wdata = wdata;
        if (is_store) exp_mem[aligned] = tb_merge(exp_read(aligned), wdata, be);
        else          sb_q.push_back(exp_read(aligned));
        stall_cycles = 0;
        saw_req      = 1'b0;
        req_addr     = '0;
        req_we       = 1'b0;
        req_be       = '0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (mem_req && !saw_req) begin
                saw_req  = 1'b1;
                req_addr = mem_addr;
                req_we   = mem_we;
                req_be   = mem_be;
            end
            if (!stall) break;
            stall_cycles++;
        end
        checkOutput({name, ":stall_released"}, {31'd0, stall}, 32'd0);
        checkOutput({name, ":stall_cycles"}, stall_cycles, exp_access ? ack_delay : 0);
        checkOutput({name, ":mem_access"}, {31'd0, saw_req}, {31'd0, exp_access});
        if (exp_access) begin
            checkOutput({name, ":mem_addr"}, req_addr, aligned);
            checkOutput({name, ":mem_addr_held"}, mem_addr, aligned);
            checkOutput({name, ":mem_we"}, {31'd0, req_we}, {31'd0, is_store});
            if (is_store) checkOutput({name, ":mem_be"}, {28'd0, req_be}, {28'd0, be});
        end
        if (!is_store) begin
            exp_data = sb_q.pop_front();
            checkOutput({name, ":rdata"}, cpu_rdata, exp_data);
            last_load = exp_data;
            if (exp_access) exp_misses++;
            else            exp_hits++;
        end
        @(posedge clk);
        #1;
        if (exp_access) checkOutput({name, ":req_drop"}, {31'd0, mem_req}, 32'd0);
    endtask

    task automatic idleCycle(input string name);
        cpu_re = 1'b0;
        cpu_we = 1'b0;
        @(negedge clk);
        checkOutput({name, ":hold_rdata"}, cpu_rdata, last_load);
        checkOutput({name, ":idle_stall"}, {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        cpu_re    = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_be    = '0;
        cpu_wdata = '0;
        mem_rdata = '0;
        mem_ack   = 1'b0;
        back_mem[32'h100] = 32'hDEADBEEF;
        exp_mem[32'h100]  = 32'hDEADBEEF;

        @(negedge clk);
        checkOutput("reset:mem_req", {31'd0, mem_req}, 32'd0);
        checkOutput("reset:mem_we", {31'd0, mem_we}, 32'd0);
        checkOutput("reset:mem_be", {28'd0, mem_be}, 32'd0);
        checkOutput("reset:mem_addr", mem_addr, 32'd0);
        checkOutput("reset:mem_wdata", mem_wdata, 32'd0);
        checkOutput("reset:stall", {31'd0, stall}, 32'd0);
        checkOutput("reset:cpu_rdata", cpu_rdata, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        ack_delay = 3;
        applyStimulus(1'b0, 1'b0, 32'h100, 4'h0, 32'h0, 1'b1, "cold_miss");
        applyStimulus(1'b0, 1'b0, 32'h100, 4'h0, 32'h0, 1'b0, "load_hit");
        ack_delay = 1;
        applyStimulus(1'b1, 1'b0, 32'h102, 4'b0100, 32'h00AA0000, 1'b1, "store_hit");
        applyStimulus(1'b0, 1'b0, 32'h100, 4'h0, 32'h0, 1'b0, "merged_hit");
        idleCycle("idle_after_merge");

        ack_delay = 2;
        applyStimulus(1'b1, 1'b0, 32'h200, 4'b1111, 32'h12345678, 1'b1, "store_miss");
        applyStimulus(1'b0, 1'b0, 32'h200, 4'h0, 32'h0, 1'b1, "no_allocate");
        applyStimulus(1'b0, 1'b0, 32'h100, 4'h0, 32'h0, 1'b1, "refill_100");
        applyStimulus(1'b0, 1'b0, 32'h140, 4'h0, 32'h0, 1'b1, "conflict_140");
        applyStimulus(1'b0, 1'b0, 32'h100, 4'h0, 32'h0, 1'b1, "conflict_100");

        for (int i = 0; i < 6; i++) begin
            ack_delay = 1 + (i % 3);
            applyStimulus(1'b0, 1'b0, 32'h400 + 32'(i * 4) + 32'(i % 4), 4'h0, 32'h0, 1'b1, "sweep_miss");
        end
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h400 + 32'(i * 4), 4'h0, 32'h0, 1'b0, "sweep_hit");
        end
        ack_delay = 2;
        applyStimulus(1'b1, 1'b1, 32'h404, 4'b0011, 32'hCAFE5A5A, 1'b1, "store_with_re");
        applyStimulus(1'b0, 1'b0, 32'h404, 4'h0, 32'h0, 1'b0, "store_with_re_hit");
        idleCycle("idle_after_sweep");

        ack_delay = 100;
        cpu_re   = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h180;
        repeat (3) @(negedge clk);
        checkOutput("fill_pending:mem_req", {31'd0, mem_req}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("in_reset:stall", {31'd0, stall}, 32'd0);
        checkOutput("in_reset:cpu_rdata", cpu_rdata, 32'd0);
        @(posedge clk);
        #1;
        cpu_re = 1'b0;
        @(negedge clk);
        checkOutput("after_reset:mem_req", {31'd0, mem_req}, 32'd0);
        checkOutput("after_reset:stall", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        exp_hits   = 0;
        exp_misses = 0;
        ack_delay  = 2;
        applyStimulus(1'b0, 1'b0, 32'h100, 4'h0, 32'h0, 1'b1, "post_reset_miss");
        applyStimulus(1'b0, 1'b0, 32'h100, 4'h0, 32'h0, 1'b0, "post_reset_hit");

`ifdef DCACHE_PERF_CNT_EN
        @(negedge clk);
        checkOutput("perf:hit_cnt", hit_cnt, exp_hits);
        checkOutput("perf:miss_cnt", miss_cnt, exp_misses);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
